tattr_blit_dma: RTL and testbench
=================================

// Module: tattr_blit_dma
// PURPOSE
//  Owns the CPU-side port of the video unit's tile-attribute RAM and shares it between direct
//  CPU accesses and a small blit engine. The engine fills or copies byte runs, optionally only
//  during vertical blank. CPU accesses always win; the engine uses free cycles.
//  Sits between the bus decoder and video_unit tattr_* ports; single clock domain (write clock).
// PARAMETERS
//  ADDR_WIDTH  10  tile-attribute RAM address width (1024 entries)
// PORTS
//  clk           in   1           clock (same clock as the RAM write port)
//  rst_n         in   1           reset; asynchronous, active-low
//  cpu_addr      in   ADDR_WIDTH  CPU byte address
//  cpu_wdata     in   8           CPU write data
//  cpu_wenable   in   1           CPU write strobe
//  cpu_renable   in   1           CPU read strobe (marks the port as busy for the cycle)
//  cpu_rdata     out  8           = ram_rdata; valid the cycle after cpu_renable
//  cfg_sel       in   2           0=SRC 1=DST 2=LEN 3=CTRL
//  cfg_wdata     in   16          config write data
//  cfg_wenable   in   1           config write strobe
//  vblank        in   1           high during vertical blank (already synchronous to clk)
//  busy          out  1           transfer in progress
//  done          out  1           sticky completion flag
//  remaining     out  ADDR_WIDTH+1 bytes still to write
//  ram_addr      out  ADDR_WIDTH  to tattr_addr
//  ram_wdata     out  8           to tattr_wdata
//  ram_wenable   out  1           to tattr_wenable
//  ram_rdata     in   8           from tattr_rdata (synchronous, 1-cycle read latency)
// BEHAVIOUR
//  Reset: FSM=IDLE; busy=0; done=0; remaining=0; SRC=DST=LEN=0; mode, vb_only, fill value = 0.
//   ram_wenable is forced low immediately, regardless of the clock.
//  Port mux (combinational):
//   - cpu_act = cpu_wenable|cpu_renable.
//   - When cpu_act: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_wenable=cpu_wenable.
//   - Otherwise the engine drives the port; ram_wenable=1 only in an engine write slot.
//  Config writes:
//   - SRC/DST/LEN take cfg_wdata[ADDR_WIDTH:0] truncated to the register width. They are
//     ignored while busy.
//   - CTRL bits: [0] start, [1] mode (0 fill, 1 copy), [2] vb_only, [3] abort, [4] clr_done,
//     [15:8] fill value.
//   - start while busy is ignored. abort and start in the same write: abort wins.
//   - start clears done and loads the working counters (src_p, dst_p, remaining=LEN).
//  FSM states: IDLE, RD, CAP, WR.
//   - Start: if LEN==0, done=1 next cycle, stay IDLE, no RAM write. Otherwise busy=1;
//     go to RD (copy) or WR (fill).
//   - Gating: go = !cpu_act & (!vb_only | vblank). In RD and WR the FSM holds while !go.
//   - RD (copy): when go, drive ram_addr=src_p and move to CAP.
//   - CAP: hold <= ram_rdata unconditionally (this is the output for the RD address issued
//     last cycle). Move to WR even if the CPU uses the port in this cycle.
//   - WR: when go, ram_addr=dst_p, ram_wdata = hold (copy) or fill value (fill).
//     Then dst_p+1 and remaining-1; for copy also src_p+1.
//     If remaining was 1: IDLE, busy=0, done=1. Else RD (copy) or WR (fill).
//  Throughput and ordering:
//   - Fill: 1 byte/clk. Copy: 3 clks/byte minimum.
//   - Addresses increase and wrap modulo 2^ADDR_WIDTH.
//   - Overlapping copy is byte-sequential: DST=SRC+1 replicates byte SRC.
//  vblank falling mid-transfer (vb_only): pause at the next RD/WR. A byte already read
//   still completes its WR before the pause.
//  abort while busy: IDLE next cycle, busy=0, done unchanged, no further engine writes.
//  clr_done clears done. If completion happens in the same cycle, completion wins (done=1).
//  rst_n low mid-transfer: abandon immediately and return all state to reset values.
// TESTING
//  1 Fill: DST=0x010, LEN=4, CTRL=0x5A01 -> writes 0x5A to 0x010..0x013 on 4 consecutive
//    clks; busy 4 clks, then done=1.
//  2 Copy: RAM[0x20..0x22]=11,22,33; SRC=0x20, DST=0x100, LEN=3, CTRL=0x0003
//    -> RAM[0x100..0x102]=11,22,33; 9 clks; done=1.
//  3 Preempt: fill LEN=8 with cpu_wenable held 3 clks mid-run -> CPU writes land; fill
//    completes 3 clks late with all 8 bytes correct; cpu_rdata correct during the stall.
//  4 Vblank: vb_only=1, vblank=0 -> no engine writes; raise vblank -> writes proceed; drop
//    vblank after 2 bytes -> pause with remaining=LEN-2.
//  5 Edges: LEN=0 -> done next clk with 0 writes. DST=0x3FE, LEN=4 fill
//    -> writes 0x3FE, 0x3FF, 0x000, 0x001.
//  6 Abort/reset: abort on the 3rd byte -> exactly 2 or 3 writes, busy=0, done=0.
//    rst_n low mid-copy -> ram_wenable=0 at once; all outputs at reset values.

Source files
------------

// File: rtl/tattr_blit_dma.sv
// Tile-attribute RAM port owner: muxes CPU accesses with a fill/copy blit engine.
// CPU accesses always take the port; the engine only uses free (and optionally vblank) cycles.
module tattr_blit_dma #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  input  logic                  cpu_wenable,
  input  logic                  cpu_renable,
  output logic [7:0]            cpu_rdata,
  input  logic [1:0]            cfg_sel,
  input  logic [15:0]           cfg_wdata,
  input  logic                  cfg_wenable,
  input  logic                  vblank,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   remaining,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_wenable,
  input  logic [7:0]            ram_rdata
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   src_q, dst_q, src_p, dst_p;
  logic [CW-1:0]   len_q;
  logic            mode_q, vb_only_q;
  logic [7:0]      fill_q, hold_q;

  logic            cpu_act, go, cfg_ctrl;
  logic            start_cmd, abort_cmd, clr_cmd;
  logic            eng_rd, eng_wr, last;
  logic [AW-1:0]   eng_addr;
  logic [7:0]      eng_wdata;
  logic            unused_ok;

  assign unused_ok = ^cfg_wdata;

  // Arbitration and command decode
  assign cpu_act   = cpu_wenable | cpu_renable;
  assign go        = ~cpu_act & (~vb_only_q | vblank);
  assign cfg_ctrl  = cfg_wenable & (cfg_sel == 2'd3);
  assign abort_cmd = cfg_ctrl & cfg_wdata[3] & (state_q != IDLE);
  assign start_cmd = cfg_ctrl & cfg_wdata[0] & ~cfg_wdata[3] & (state_q == IDLE);
  assign clr_cmd   = cfg_ctrl & cfg_wdata[4];
  assign eng_rd    = (state_q == RD) & go;
  assign eng_wr    = (state_q == WR) & go & ~abort_cmd;
  assign last      = eng_wr & (remaining == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    eng_addr  = dst_p;
    eng_wdata = mode_q ? hold_q : fill_q;
    case (state_q)
      IDLE: if (start_cmd && (len_q != '0)) state_d = cfg_wdata[1] ? RD : WR;
      RD: begin
        eng_addr = src_p;
        if (eng_rd) state_d = CAP;
      end
      CAP:  state_d = WR;
      WR:   if (eng_wr) state_d = last ? IDLE : (mode_q ? RD : WR);
      default: state_d = IDLE;
    endcase
    if (abort_cmd) state_d = IDLE;
  end

  // Shared RAM port; write enable drops the instant reset asserts
  assign ram_addr    = cpu_act ? cpu_addr  : eng_addr;
  assign ram_wdata   = cpu_act ? cpu_wdata : eng_wdata;
  assign ram_wenable = rst_n & (cpu_wenable | eng_wr);
  assign cpu_rdata   = ram_rdata;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      vb_only_q <= 1'b0;
      fill_q    <= '0;
      hold_q    <= '0;
      src_p     <= '0;
      dst_p     <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      if (cfg_wenable && !busy) begin
        case (cfg_sel)
          2'd0: src_q <= cfg_wdata[AW-1:0];
          2'd1: dst_q <= cfg_wdata[AW-1:0];
          2'd2: len_q <= cfg_wdata[CW-1:0];
          default: begin
            mode_q    <= cfg_wdata[1];
            vb_only_q <= cfg_wdata[2];
            fill_q    <= cfg_wdata[15:8];
          end
        endcase
      end
      if (state_q == CAP) hold_q <= ram_rdata;
      if (eng_wr) begin
        dst_p     <= dst_p + AW'(1);
        remaining <= remaining - CW'(1);
        if (mode_q) src_p <= src_p + AW'(1);
      end
      if (start_cmd) begin
        src_p     <= src_q;
        dst_p     <= dst_q;
        remaining <= len_q;
      end
      // Completion outranks a simultaneous clr_done
      if (last)           done <= 1'b1;
      else if (start_cmd) done <= (len_q == '0);
      else if (clr_cmd)   done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tattr_blit_dma.sv
// Scoreboard bench for tattr_blit_dma: a byte-level reference of the RAM predicts every
// engine write and CPU read; a monitor compares them as the DUT presents them.
module tb_tattr_blit_dma;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_wenable = 1'b0, cpu_renable = 1'b0;
  logic [7:0]    cpu_rdata;
  logic [1:0]    cfg_sel = '0;
  logic [15:0]   cfg_wdata = '0;
  logic          cfg_wenable = 1'b0;
  logic          vblank = 1'b0;
  logic          busy, done;
  logic [AW:0]   remaining;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_wenable;
  logic [7:0]    ram_rdata;

  tattr_blit_dma #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wenable(cpu_wenable),
    .cpu_renable(cpu_renable), .cpu_rdata(cpu_rdata),
    .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_wenable(cfg_wenable),
    .vblank(vblank), .busy(busy), .done(done), .remaining(remaining),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wenable(ram_wenable),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       addr;
    int       data;
    int       old;
  } wr_t;

  wr_t      exp_wq[$];
  int       exp_rq[$];
  logic [7:0] ram [DEPTH];
  int       ref_mem [DEPTH];
  int       checks = 0, errors = 0, eng_cnt = 0;
  logic     rd_pend = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tile-attribute RAM: synchronous write and read, one-cycle read latency
  always @(posedge clk) begin
    if (ram_wenable) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
    rd_pend   <= rst_n && cpu_renable;
  end

  // Monitor: every port transaction is compared against the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (cpu_wenable || cpu_renable) begin
        check("cpu_port", int'(ram_addr == cpu_addr && ram_wenable == cpu_wenable &&
              (!cpu_wenable || ram_wdata == cpu_wdata)), 1);
      end else if (ram_wenable) begin
        eng_cnt++;
        if (exp_wq.size() == 0) begin
          check("eng_write_unexpected", int'(ram_addr), -1);
        end else begin
          e = exp_wq.pop_front();
          check("eng_addr", int'(ram_addr), e.addr);
          check("eng_data", int'(ram_wdata), e.data);
        end
      end
      if (rd_pend) begin
        if (exp_rq.size() == 0) check("cpu_read_unexpected", int'(cpu_rdata), -1);
        else                    check("cpu_rdata", int'(cpu_rdata), exp_rq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu_wr(input int a, input int d);
    cpu_addr = AW'(a); cpu_wdata = 8'(d);
    cpu_wenable = 1'b1; cpu_renable = 1'b0;
    ref_mem[a] = d & 8'hFF;
  endtask

  task automatic drive_cpu_rd(input int a);
    cpu_addr = AW'(a); cpu_wenable = 1'b0; cpu_renable = 1'b1;
    exp_rq.push_back(ref_mem[a]);
  endtask

  task automatic cpu_idle();
    cpu_wenable = 1'b0; cpu_renable = 1'b0;
  endtask

  task automatic cpu_wr(input int a, input int d);
    drive_cpu_wr(a, d); step(); cpu_idle();
  endtask

  task automatic cfg_wr(input int sel, input int d);
    cfg_sel = 2'(sel); cfg_wdata = 16'(d); cfg_wenable = 1'b1;
    step();
    cfg_wenable = 1'b0;
  endtask

  // Reference: byte i of a transfer writes DST+i (mod depth) with the fill value or with
  // whatever SRC+i holds at that moment, so overlapping copies behave byte-sequentially.
  task automatic push_xfer(input bit mode, input int src, input int dst, input int len,
                           input int fill);
    wr_t e;
    for (int i = 0; i < len; i++) begin
      e.addr = (dst + i) % DEPTH;
      e.data = mode ? ref_mem[(src + i) % DEPTH] : (fill & 8'hFF);
      e.old  = ref_mem[e.addr];
      ref_mem[e.addr] = e.data;
      exp_wq.push_back(e);
    end
  endtask

  // Bytes that were predicted but never written (abort/reset) are returned to their old value
  task automatic flush_restore();
    wr_t e;
    while (exp_wq.size() > 0) begin
      e = exp_wq.pop_back();
      ref_mem[e.addr] = e.old;
    end
  endtask

  task automatic run_xfer(input bit mode, input int src, input int dst, input int len,
                          input int fill, input bit vb, input int exp_cyc,
                          input int pre_at, input bit rnd);
    int cnt, r;
    cfg_wr(0, src); cfg_wr(1, dst); cfg_wr(2, len);
    push_xfer(mode, src, dst, len, fill);
    cfg_wr(3, ((fill & 8'hFF) << 8) | (int'(vb) << 2) | (int'(mode) << 1) | 1);
    cnt = 0;
    while (busy && cnt < 3000) begin
      if (pre_at >= 0 && cnt >= pre_at && cnt < pre_at + 2) begin
        drive_cpu_wr('h200 + (cnt % 64), $urandom_range(0, 255));
      end else if (pre_at >= 0 && cnt == pre_at + 2) begin
        drive_cpu_rd('h200 + (pre_at % 64));
      end else if (rnd) begin
        vblank = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 7);
        if (r == 0)      drive_cpu_wr('h200 + $urandom_range(0, 63), $urandom_range(0, 255));
        else if (r == 1) drive_cpu_rd('h200 + $urandom_range(0, 63));
        else             cpu_idle();
      end else begin
        cpu_idle();
      end
      cnt++;
      step();
    end
    cpu_idle();
    vblank = 1'b0;
    if (busy) check("xfer_timeout", 1, 0);
    if (exp_cyc >= 0) check("busy_cycles", cnt, exp_cyc);
    check("done_after_xfer", int'(done), 1);
    check("remaining_after_xfer", int'(remaining), 0);
    check("sb_drained", exp_wq.size(), 0);
  endtask

  initial begin
    int base, n, v, mism;
    // Reset state, including the combinational write-enable
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_ram_wenable", int'(ram_wenable), 0);
    step();
    rst_n = 1'b1;
    step();

    // Preload the whole RAM through the CPU port so reference and RAM agree
    for (int a = 0; a < int'(DEPTH); a++) cpu_wr(a, $urandom_range(0, 255));

    // Fill: 4 bytes on 4 consecutive clocks
    run_xfer(1'b0, 0, 'h010, 4, 'h5A, 1'b0, 4, -1, 1'b0);
    check("fill_mem_end", int'(ram['h013]), 'h5A);

    // Copy: 3 bytes, 3 clocks each
    cpu_wr('h20, 'h11); cpu_wr('h21, 'h22); cpu_wr('h22, 'h33);
    run_xfer(1'b1, 'h20, 'h100, 3, 0, 1'b0, 9, -1, 1'b0);
    check("copy_mem_0", int'(ram['h100]), 'h11);
    check("copy_mem_2", int'(ram['h102]), 'h33);

    // Overlapping copy replicates the source byte
    v = ref_mem['h40];
    run_xfer(1'b1, 'h40, 'h41, 5, 0, 1'b0, 15, -1, 1'b0);
    check("overlap_mem", int'(ram['h45]), v);

    // CPU preempts a fill for 3 clocks (2 writes + 1 read)
    run_xfer(1'b0, 0, 'h080, 8, 'hA7, 1'b0, 11, 2, 1'b0);

    // vblank-gated fill
    cfg_wr(1, 'h0C0); cfg_wr(2, 6);
    push_xfer(1'b0, 0, 'h0C0, 6, 'h3C);
    base = eng_cnt;
    cfg_wr(3, 'h3C05);
    repeat (5) step();
    check("vb_no_writes", eng_cnt - base, 0);
    check("vb_hold_remaining", int'(remaining), 6);
    vblank = 1'b1; step(); step();
    vblank = 1'b0; repeat (3) step();
    check("vb_pause_writes", eng_cnt - base, 2);
    check("vb_pause_remaining", int'(remaining), 4);
    check("vb_pause_busy", int'(busy), 1);
    vblank = 1'b1;
    n = 0;
    while (busy && n < 50) begin n++; step(); end
    vblank = 1'b0;
    check("vb_done", int'(done), 1);
    check("vb_total_writes", eng_cnt - base, 6);

    // clr_done, then LEN=0 completes at once without writes
    cfg_wr(3, 'h0010);
    check("clr_done", int'(done), 0);
    cfg_wr(2, 0);
    base = eng_cnt;
    cfg_wr(3, 'h0001);
    check("len0_done", int'(done), 1);
    check("len0_busy", int'(busy), 0);
    step();
    check("len0_no_writes", eng_cnt - base, 0);

    // Address wrap
    run_xfer(1'b0, 0, 'h3FE, 4, 'hC3, 1'b0, 4, -1, 1'b0);
    check("wrap_mem", int'(ram['h001]), 'hC3);

    // Abort on the third byte
    cfg_wr(1, 'h060); cfg_wr(2, 8);
    push_xfer(1'b0, 0, 'h060, 8, 'h99);
    base = eng_cnt;
    cfg_wr(3, 'h9901);
    step(); step();
    cfg_wr(3, 'h0008);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (4) step();
    n = eng_cnt - base;
    check("abort_writes", int'(n == 2 || n == 3), 1);
    flush_restore();

    // Reset in the middle of a copy write slot
    cfg_wr(0, 'h020); cfg_wr(1, 'h140); cfg_wr(2, 8);
    push_xfer(1'b1, 'h020, 'h140, 8, 0);
    cfg_wr(3, 'h0003);
    step(); step();
    check("copy_wr_slot", int'(ram_wenable), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ram_wenable", int'(ram_wenable), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_remaining", int'(remaining), 0);
    flush_restore();
    step(); step();
    rst_n = 1'b1;
    step();
    base = eng_cnt;
    cfg_wr(3, 'h0001);
    check("post_rst_len0_done", int'(done), 1);
    step();
    check("post_rst_no_writes", eng_cnt - base, 0);

    // Randomized transfers with random CPU traffic and vblank
    for (int t = 0; t < 14; t++) begin
      run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 'h1E0), $urandom_range(0, 'h1E0),
               $urandom_range(1, 16), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
               -1, -1, 1'b1);
    end

    repeat (3) step();
    check("rd_q_drained", exp_rq.size(), 0);
    mism = 0;
    for (int a = 0; a < int'(DEPTH); a++) if (int'(ram[a]) != ref_mem[a]) mism++;
    check("mem_image", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
